spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
- SPI master that sits between the FSM processor core and the SPI slave peripherals. It drives sck, ss and mosi, and captures miso.
- The processor hands over one DATA_W-bit word plus a start strobe. The block runs a full mode-0 transfer (CPOL=0, CPHA=0, MSB first, active-low ss), then returns the received word with a one-cycle done pulse.
- Slaves sample mosi and advance their miso on the rising edge of sck. The master therefore changes mosi only while sck is low and samples miso at rising sck.

Parameters:
- DATA_W, 8: bits per transfer.
- CLK_DIV, 2: clk cycles per sck half-period. Legal range is 1 to 255. A value of 0 is illegal (the bench asserts on it).

Ports:
- clk, input, 1: system clock; all logic is on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: transfer request; accepted only when busy=0.
- tx_data, input, DATA_W: word to send; latched in the cycle start is accepted.
- keep_ss, input, 1: latched with start; 1 means ss stays low after this transfer ends.
- busy, output, 1: high from the accept edge until the done cycle.
- done, output, 1: one-clk pulse at transfer end.
- rx_data, output, DATA_W: received word; updated in the done cycle, held otherwise.
- sck, output, 1: serial clock; idles low.
- ss, output, 1: slave select, active low; idles high.
- mosi, output, 1: serial data out.
- miso, input, 1: serial data in.

Behaviour:
- Reset (async, rst_n=0): sck=0, ss=1, mosi=0, busy=0, done=0, rx_data=0, state=IDLE, divider=0, bit counter=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States are IDLE, LEAD, HIGH, LOW, TRAIL. Each non-IDLE phase lasts exactly CLK_DIV clk cycles, timed by a down-counter reloaded to CLK_DIV-1.
- IDLE: when start=1 at edge T0:
  - latch tx_data into the shift register and latch keep_ss;
  - set ss=0, mosi=tx_data[DATA_W-1], busy=1, bit counter=0;
  - go to LEAD.
- start while busy=1 is ignored, with no side effects.
- LEAD to HIGH: sck=1. In the same clk edge, miso is shifted into the receive register LSB (the sample uses the pre-edge miso value).
- HIGH to LOW, when the bit counter is below DATA_W-1:
  - sck=0;
  - mosi = next tx bit (MSB-first order);
  - increment the bit counter.
- HIGH to TRAIL, when the bit counter equals DATA_W-1: sck=0 and mosi holds its last value.
- LOW to HIGH: same actions as LEAD to HIGH.
- TRAIL to IDLE:
  - done=1 for one cycle;
  - rx_data = receive register;
  - busy=0;
  - ss=1 unless the latched keep_ss=1, in which case ss stays 0;
  - mosi=0.
- Timing, relative to accept edge T0 with D=CLK_DIV:
  - sck rises at T0+(2k+1)D for k=0 to DATA_W-1;
  - sck falls at T0+(2k+2)D;
  - done, busy low and ss release occur at T0+(2*DATA_W+1)D.
  - For DATA_W=8 and D=2, done arrives 34 cycles after accept.
- Back-to-back: start may be asserted in the done cycle and is accepted on the next edge. In that case ss goes high for exactly one cycle (keep_ss=0), or stays low throughout (keep_ss=1).
- With ss already low from keep_ss, a new transfer still spends the full D-cycle LEAD phase.
- ss held low by keep_ss is released only by the end of a transfer with keep_ss=0, or by reset.
- Reset asserted mid-transfer aborts immediately to the reset values. No done pulse is generated and rx_data is cleared.
- done never coincides with busy=1. A done pulse occurs only at the TRAIL to IDLE transition.

Test Plan:
- Reset: hold rst_n=0 with random inputs, including toggling miso and start, → sck=0, ss=1, mosi=0, busy=0, done=0, rx_data=0 throughout reset.
- Loopback: miso tied to mosi, D=2, send tx_data=0xA5 → mosi sequence 1,0,1,0,0,1,0,1; 8 sck pulses, each 2 high plus 2 low; done exactly 34 cycles after accept; rx_data=0xA5; ss low for 34 cycles.
- Slave model: mode-0 model returns 0x3C while receiving 0xF0, D=1 → rx_data=0x3C; done 17 cycles after accept; model captured 0xF0.
- Busy rejection: assert start with tx_data=0x11, then pulse start with tx_data=0xFF at cycles 3 and 10 → only 0x11 is transmitted; exactly one done pulse.
- keep_ss chain: transfer 0x01 with keep_ss=1, then start in the done cycle with 0x02 and keep_ss=0 → ss stays low continuously across both transfers; two done pulses; ss high after the second.
- Abort: pull rst_n low after the 4th rising sck edge → sck=0 and ss=1 asynchronously; no done pulse; a following transfer of 0x5A completes normally.

Source files
------------

// File: rtl/spi_master_ctrl.sv
`timescale 1ns/1ps
// spi_master_ctrl
// Mode-0 SPI master (CPOL=0, CPHA=0, MSB first, active-low ss).
// One DATA_W-bit word is shifted out on mosi while the same number of
// bits is captured from miso. The received word is returned together
// with a single-cycle done pulse.
//
// Phase sequence for one transfer:
//   IDLE -> LEAD -> HIGH -> LOW -> HIGH -> ... -> HIGH -> TRAIL -> IDLE
// Every non-IDLE phase lasts CLK_DIV clk cycles. A down-counter is reloaded
// with CLK_DIV-1 on entry to each phase, and the phase ends when it reads zero.
//
// Every output comes straight from a flop. The combinational process only
// computes next-state values, so no input reaches an output in the same cycle.
module spi_master_ctrl #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              keep_ss,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sck,
    output logic              ss,
    output logic              mosi,
    input  logic              miso
);

    // Bit counter only needs to reach DATA_W-1.
    localparam int               CNT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [7:0]       DIV_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW,
        TRAIL
    } state_t;

    // Registered state
    state_t            r_state;
    logic [7:0]        r_div;
    logic [CNT_W-1:0]  r_bit;
    logic [DATA_W-1:0] r_tx_sr;
    logic [DATA_W-1:0] r_rx_sr;
    logic              r_keep;
    logic              r_sck;
    logic              r_ss;
    logic              r_mosi;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_rx_data;

    // Next-state values
    state_t            w_state_next;
    logic [7:0]        w_div_next;
    logic [CNT_W-1:0]  w_bit_next;
    logic [DATA_W-1:0] w_tx_sr_next;
    logic [DATA_W-1:0] w_rx_sr_next;
    logic              w_keep_next;
    logic              w_sck_next;
    logic              w_ss_next;
    logic              w_mosi_next;
    logic              w_busy_next;
    logic              w_done_next;
    logic [DATA_W-1:0] w_rx_data_next;

    // Helper wires
    logic              w_phase_end;
    logic [DATA_W-1:0] w_tx_shift;

    assign w_phase_end = (r_div == 8'd0);
    assign w_tx_shift  = r_tx_sr << 1;

    assign sck     = r_sck;
    assign ss      = r_ss;
    assign mosi    = r_mosi;
    assign busy    = r_busy;
    assign done    = r_done;
    assign rx_data = r_rx_data;

    // Next-state and next-output logic. Every value holds by default,
    // and done is a pulse that clears itself.
    always_comb begin
        w_state_next   = r_state;
        w_div_next     = r_div;
        w_bit_next     = r_bit;
        w_tx_sr_next   = r_tx_sr;
        w_rx_sr_next   = r_rx_sr;
        w_keep_next    = r_keep;
        w_sck_next     = r_sck;
        w_ss_next      = r_ss;
        w_mosi_next    = r_mosi;
        w_busy_next    = r_busy;
        w_done_next    = 1'b0;
        w_rx_data_next = r_rx_data;

        case (r_state)
            IDLE: begin
                // ss may already be low here if the previous transfer used
                // keep_ss. LEAD still runs in full, so mosi gets a whole
                // half-period of setup before the first rising sck.
                if (start) begin
                    w_tx_sr_next = tx_data;
                    w_keep_next  = keep_ss;
                    w_ss_next    = 1'b0;
                    w_mosi_next  = tx_data[DATA_W-1];
                    w_busy_next  = 1'b1;
                    w_bit_next   = '0;
                    w_div_next   = DIV_RELOAD;
                    w_state_next = LEAD;
                end
            end

            LEAD, LOW: begin
                if (w_phase_end) begin
                    // Rising sck. miso is sampled here with its pre-edge
                    // value, which is the bit the slave presented before
                    // it advances on this same edge.
                    w_sck_next   = 1'b1;
                    w_rx_sr_next = DATA_W'({r_rx_sr, miso});
                    w_div_next   = DIV_RELOAD;
                    w_state_next = HIGH;
                end else begin
                    w_div_next = r_div - 8'd1;
                end
            end

            HIGH: begin
                if (w_phase_end) begin
                    w_sck_next = 1'b0;
                    w_div_next = DIV_RELOAD;
                    if (r_bit == LAST_BIT) begin
                        // mosi keeps the last bit through the trailing phase.
                        w_state_next = TRAIL;
                    end else begin
                        // Falling sck: present the next MSB-first bit.
                        w_tx_sr_next = w_tx_shift;
                        w_mosi_next  = w_tx_shift[DATA_W-1];
                        w_bit_next   = r_bit + CNT_W'(1);
                        w_state_next = LOW;
                    end
                end else begin
                    w_div_next = r_div - 8'd1;
                end
            end

            TRAIL: begin
                if (w_phase_end) begin
                    w_done_next    = 1'b1;
                    w_rx_data_next = r_rx_sr;
                    w_busy_next    = 1'b0;
                    w_ss_next      = ~r_keep;
                    w_mosi_next    = 1'b0;
                    w_state_next   = IDLE;
                end else begin
                    w_div_next = r_div - 8'd1;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State and output registers. Reset aborts any transfer immediately
    // and does not produce a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_div     <= 8'd0;
            r_bit     <= '0;
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_keep    <= 1'b0;
            r_sck     <= 1'b0;
            r_ss      <= 1'b1;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rx_data <= '0;
        end else begin
            r_state   <= w_state_next;
            r_div     <= w_div_next;
            r_bit     <= w_bit_next;
            r_tx_sr   <= w_tx_sr_next;
            r_rx_sr   <= w_rx_sr_next;
            r_keep    <= w_keep_next;
            r_sck     <= w_sck_next;
            r_ss      <= w_ss_next;
            r_mosi    <= w_mosi_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
            r_rx_data <= w_rx_data_next;
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
`timescale 1ns/1ps
// Directed testbench for spi_master_ctrl.
// dut_a (CLK_DIV=2) runs with miso looped back to its own mosi.
// dut_b (CLK_DIV=1) talks to a behavioural mode-0 slave.
// Outputs are sampled on the falling clock edge.
module tb_spi_master_ctrl;

    localparam int DW    = 8;
    localparam int DIV_A = 2;
    localparam int DIV_B = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [DW-1:0] tx_data;
    logic          keep_ss;
    logic          start_a, start_b;
    logic          loop_a, miso_drv;

    logic busy_a, done_a, sck_a, ss_a, mosi_a, miso_a;
    logic busy_b, done_b, sck_b, ss_b, mosi_b;
    logic miso_b = 1'b0;
    logic [DW-1:0] rx_a, rx_b;

    int checks;
    int errors;

    assign miso_a = loop_a ? mosi_a : miso_drv;

    spi_master_ctrl #(.DATA_W(DW), .CLK_DIV(DIV_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .tx_data(tx_data),
        .keep_ss(keep_ss), .busy(busy_a), .done(done_a), .rx_data(rx_a),
        .sck(sck_a), .ss(ss_a), .mosi(mosi_a), .miso(miso_a)
    );

    spi_master_ctrl #(.DATA_W(DW), .CLK_DIV(DIV_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .tx_data(tx_data),
        .keep_ss(keep_ss), .busy(busy_b), .done(done_b), .rx_data(rx_b),
        .sck(sck_b), .ss(ss_b), .mosi(mosi_b), .miso(miso_b)
    );

    // A divider of 0 is not a legal configuration.
    initial begin
        assert (DIV_A >= 1 && DIV_A <= 255 && DIV_B >= 1 && DIV_B <= 255)
            else $fatal(1, "illegal CLK_DIV");
    end

    // Mode-0 slave: loads its first bit when ss falls, then on every rising
    // sck it samples mosi and advances miso.
    logic [7:0] slv_load = 8'h00;
    logic [7:0] slv_tx   = 8'h00;
    logic [7:0] slv_rx   = 8'h00;
    always @(negedge ss_b or posedge sck_b) begin
        if (sck_b) begin
            slv_rx = {slv_rx[6:0], mosi_b};
            slv_tx = slv_tx << 1;
            miso_b = slv_tx[7];
        end else begin
            slv_tx = slv_load;
            slv_rx = 8'h00;
            miso_b = slv_tx[7];
        end
    end

    // Runs one transfer on dut_a and records what it observes. It is entered
    // and left on a falling edge. Index k counts clk edges after the accept edge.
    task automatic xfer_a(input logic [7:0] tx, input logic ks,
                          output int done_at, output logic [7:0] bits,
                          output int rises, output int ss_low, output int bad_runs);
        logic prev;
        int   run;
        done_at = -1; bits = 8'h00; rises = 0; ss_low = 0; bad_runs = 0;
        prev = 1'b0; run = 0;
        tx_data = tx; keep_ss = ks; start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (sck_a != prev) begin
                if (run != DIV_A) bad_runs++;
                run = 0;
                if (sck_a) begin
                    rises++;
                    bits = {bits[6:0], mosi_a};
                end
            end
            run++;
            if (!ss_a) ss_low++;
            prev = sck_a;
            if (done_a) begin
                done_at = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if ({sck_a, ss_a, mosi_a, busy_a, done_a, rx_a} !== {4'b0100, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL reset_a cyc=%0d got sck=%b ss=%b mosi=%b busy=%b done=%b rx=%h want 0 1 0 0 0 00",
                         i, sck_a, ss_a, mosi_a, busy_a, done_a, rx_a);
            end
            checks++;
            if ({sck_b, ss_b, mosi_b, busy_b, done_b, rx_b} !== {4'b0100, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL reset_b cyc=%0d got sck=%b ss=%b mosi=%b busy=%b done=%b rx=%h want 0 1 0 0 0 00",
                         i, sck_b, ss_b, mosi_b, busy_b, done_b, rx_b);
            end
            start_a  = 1'($urandom_range(0, 1));
            start_b  = 1'($urandom_range(0, 1));
            miso_drv = 1'($urandom_range(0, 1));
            tx_data  = 8'($urandom);
            keep_ss  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; keep_ss = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({ss_a, busy_a, ss_b, busy_b} !== 4'b1010) begin
            errors++;
            $display("FAIL post_reset_idle got ss_a=%b busy_a=%b ss_b=%b busy_b=%b want 1 0 1 0",
                     ss_a, busy_a, ss_b, busy_b);
        end
    endtask

    task automatic test_loopback();
        int d, r, sl, br;
        logic [7:0] b;
        loop_a = 1'b1;
        xfer_a(8'hA5, 1'b0, d, b, r, sl, br);
        $display("loopback tx=a5 done_at=%0d mosi=%h rises=%0d ss_low=%0d rx=%h", d, b, r, sl, rx_a);
        checks++; if (d !== 34)    begin errors++; $display("FAIL loop_done_at got %0d want 34", d); end
        checks++; if (b !== 8'hA5) begin errors++; $display("FAIL loop_mosi got %h want a5", b); end
        checks++; if (r !== 8)     begin errors++; $display("FAIL loop_rises got %0d want 8", r); end
        checks++; if (br !== 0)    begin errors++; $display("FAIL loop_half_periods got %0d bad want 0", br); end
        checks++; if (sl !== 34)   begin errors++; $display("FAIL loop_ss_low got %0d want 34", sl); end
        checks++; if (rx_a !== 8'hA5 || busy_a !== 1'b0 || ss_a !== 1'b1) begin
            errors++;
            $display("FAIL loop_end got rx=%h busy=%b ss=%b want a5 0 1", rx_a, busy_a, ss_a);
        end
        @(negedge clk);
        checks++; if (done_a !== 1'b0 || rx_a !== 8'hA5) begin
            errors++;
            $display("FAIL loop_done_pulse got done=%b rx=%h want 0 a5", done_a, rx_a);
        end
    endtask

    task automatic test_slave();
        int d;
        slv_load = 8'h3C;
        d = -1;
        tx_data = 8'hF0; keep_ss = 1'b0; start_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (k == 0) begin
                checks++;
                if (busy_b !== 1'b1 || ss_b !== 1'b0) begin
                    errors++;
                    $display("FAIL slave_accept got busy=%b ss=%b want 1 0", busy_b, ss_b);
                end
            end
            if (done_b) begin d = k; break; end
            @(negedge clk);
        end
        $display("slave tx=f0 done_at=%0d rx=%h slave_got=%h", d, rx_b, slv_rx);
        checks++; if (d !== 17)       begin errors++; $display("FAIL slave_done_at got %0d want 17", d); end
        checks++; if (rx_b !== 8'h3C) begin errors++; $display("FAIL slave_rx got %h want 3c", rx_b); end
        checks++; if (slv_rx !== 8'hF0) begin errors++; $display("FAIL slave_captured got %h want f0", slv_rx); end
    endtask

    task automatic test_busy_reject();
        int dones, d, r;
        logic prev;
        logic [7:0] b;
        dones = 0; d = -1; r = 0; prev = 1'b0; b = 8'h00;
        loop_a = 1'b1;
        tx_data = 8'h11; keep_ss = 1'b0; start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (sck_a && !prev) begin r++; b = {b[6:0], mosi_a}; end
            prev = sck_a;
            if (done_a) begin dones++; d = k; end
            start_a = (k == 3 || k == 10);
            if (start_a) tx_data = 8'hFF;
            @(negedge clk);
        end
        start_a = 1'b0;
        $display("busy_reject tx=11 dones=%0d done_at=%0d mosi=%h rx=%h", dones, d, b, rx_a);
        checks++; if (dones !== 1) begin errors++; $display("FAIL reject_dones got %0d want 1", dones); end
        checks++; if (d !== 34)    begin errors++; $display("FAIL reject_done_at got %0d want 34", d); end
        checks++; if (b !== 8'h11 || r !== 8) begin
            errors++;
            $display("FAIL reject_mosi got %h rises=%0d want 11 rises=8", b, r);
        end
        checks++; if (rx_a !== 8'h11 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL reject_end got rx=%h busy=%b want 11 0", rx_a, busy_a);
        end
    endtask

    // Two chained transfers, with the second start raised in the first done
    // cycle. ks1 is keep_ss for the first transfer; the second always uses 0.
    task automatic test_back_to_back(input logic ks1, input int exp_high);
        int dones, hi, d2;
        logic [7:0] rx1, rx2;
        logic ss_end;
        dones = 0; hi = 0; d2 = -1; rx1 = 8'h00; rx2 = 8'h00; ss_end = 1'b0;
        loop_a = 1'b1;
        tx_data = 8'h01; keep_ss = ks1; start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k < 200; k++) begin
            start_a = 1'b0;
            if (done_a && dones == 1) begin
                dones++; rx2 = rx_a; ss_end = ss_a; d2 = k;
                break;
            end
            if (ss_a) hi++;
            if (done_a) begin
                dones++; rx1 = rx_a;
                tx_data = 8'h02; keep_ss = 1'b0; start_a = 1'b1;
            end
            @(negedge clk);
        end
        start_a = 1'b0;
        $display("back_to_back keep=%b dones=%0d ss_high=%0d rx1=%h rx2=%h done2_at=%0d ss_end=%b",
                 ks1, dones, hi, rx1, rx2, d2, ss_end);
        checks++; if (dones !== 2)    begin errors++; $display("FAIL b2b_dones keep=%b got %0d want 2", ks1, dones); end
        checks++; if (hi !== exp_high) begin errors++; $display("FAIL b2b_ss_high keep=%b got %0d want %0d", ks1, hi, exp_high); end
        checks++; if (rx1 !== 8'h01 || rx2 !== 8'h02) begin
            errors++;
            $display("FAIL b2b_rx keep=%b got %h %h want 01 02", ks1, rx1, rx2);
        end
        checks++; if (d2 !== 69)     begin errors++; $display("FAIL b2b_done2_at keep=%b got %0d want 69", ks1, d2); end
        checks++; if (ss_end !== 1'b1) begin errors++; $display("FAIL b2b_ss_release keep=%b got %b want 1", ks1, ss_end); end
    endtask

    task automatic test_abort();
        int rises, d, r, sl, br, dones;
        logic prev;
        logic [7:0] b;
        rises = 0; prev = 1'b0; dones = 0;
        loop_a = 1'b1;
        tx_data = 8'h77; keep_ss = 1'b0; start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (sck_a && !prev) rises++;
            prev = sck_a;
            if (rises == 4) break;
            @(negedge clk);
        end
        checks++; if (rises !== 4) begin errors++; $display("FAIL abort_reach_4th_edge got %0d want 4", rises); end
        #2 rst_n = 1'b0;
        #1;
        $display("abort sck=%b ss=%b mosi=%b busy=%b rx=%h", sck_a, ss_a, mosi_a, busy_a, rx_a);
        checks++;
        if ({sck_a, ss_a, mosi_a, busy_a, rx_a} !== {4'b0100, 8'h00}) begin
            errors++;
            $display("FAIL abort_async got sck=%b ss=%b mosi=%b busy=%b rx=%h want 0 1 0 0 00",
                     sck_a, ss_a, mosi_a, busy_a, rx_a);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done_a) dones++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done_a) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", dones); end
        xfer_a(8'h5A, 1'b0, d, b, r, sl, br);
        $display("after_abort tx=5a done_at=%0d mosi=%h rx=%h", d, b, rx_a);
        checks++; if (d !== 34) begin errors++; $display("FAIL abort_next_done_at got %0d want 34", d); end
        checks++; if (rx_a !== 8'h5A || b !== 8'h5A) begin
            errors++;
            $display("FAIL abort_next_data got rx=%h mosi=%h want 5a 5a", rx_a, b);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        tx_data = 8'h00; keep_ss = 1'b0;
        loop_a = 1'b0; miso_drv = 1'b0;
        #1 rst_n = 1'b0;
        test_reset();
        test_loopback();
        test_slave();
        test_busy_reject();
        test_back_to_back(1'b0, 1);
        test_back_to_back(1'b1, 0);
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
